// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-width helper for regfile_sb
// Purpose: default sizing for the register file and its pending-write counters.
// Ports: none (package).
package regfile_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int NUM_REGS_DEF  = 4;
    localparam int NUM_RD_DEF    = 2;
    localparam int PEND_W_DEF    = 2;

    // A two-entry file still needs one address bit, which $clog2(2) gives,
    // but guard smaller values so a degenerate NUM_REGS never yields width 0.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ADDR_W_DEF = addr_width(NUM_REGS_DEF);

endpackage

// File: rtl/regfile_sb_pend_ctr.sv
// rtl/regfile_sb_pend_ctr.sv - saturating pending-write counter for one register
// Purpose: counts issued-but-not-written-back writes for one register.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inc_i, dec_i          issue / writeback strobes for this register
//   cnt_o                 current count
//   nz_next_o             count is nonzero after this cycle's update
//   err_inc_o, err_dec_o  issue dropped at max / writeback seen at zero
module pend_ctr import regfile_pkg::*; #(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o,
    output logic              nz_next_o,
    output logic              err_inc_o,
    output logic              err_dec_o
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] cnt_q;
    logic [PEND_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel, so neither saturation check applies.
    always_comb begin
        cnt_d     = cnt_q;
        err_inc_o = 1'b0;
        err_dec_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) err_inc_o = 1'b1;
            else                  cnt_d     = cnt_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) err_dec_o = 1'b1;
            else             cnt_d     = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign nz_next_o = |cnt_d;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with write bypass and per-register pending scoreboard
// Purpose: decode-side reads with same-cycle writeback bypass, plus pending-write
//          counters so decode can detect RAW hazards.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   rd_addr / rd_data / rd_busy      NUM_RD packed read ports (combinational)
//   wr_en / wr_addr / wr_data        writeback port
//   iss_en / iss_addr                issue of a future write to iss_addr
//   iss_err / wb_err                 registered single-cycle error pulses
//   pend_any                         registered: some counter is nonzero
module regfile_sb import regfile_pkg::*; #(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int ADDR_W    = addr_width(NUM_REGS),
    parameter int NUM_RD    = NUM_RD_DEF,
    parameter int PEND_W    = PEND_W_DEF,
    parameter int ZERO_REG  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WORD_SIZE-1:0]        wr_data,
    input  logic                        iss_en,
    input  logic [ADDR_W-1:0]           iss_addr,
    output logic                        iss_err,
    output logic                        wb_err,
    output logic                        pend_any
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [PEND_W-1:0]    cnt    [NUM_REGS];
    logic [NUM_REGS-1:0]  inc;
    logic [NUM_REGS-1:0]  dec;
    logic [NUM_REGS-1:0]  nz;
    logic [NUM_REGS-1:0]  nz_next;
    logic [NUM_REGS-1:0]  err_inc;
    logic [NUM_REGS-1:0]  err_dec;
    logic                 wr_ok;
    logic                 iss_err_q;
    logic                 wb_err_q;
    logic                 pend_any_q;

    // The hard-wired zero register swallows writes, issues and writebacks.
    assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_ctr
        localparam bit IS_ZERO = (ZERO_REG != 0) && (r == 0);

        assign inc[r] = iss_en && (iss_addr == ADDR_W'(r)) && !IS_ZERO;
        assign dec[r] = wr_en  && (wr_addr  == ADDR_W'(r)) && !IS_ZERO;

        pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clk       (clk),
            .reset     (reset),
            .inc_i     (inc[r]),
            .dec_i     (dec[r]),
            .cnt_o     (cnt[r]),
            .nz_next_o (nz_next[r]),
            .err_inc_o (err_inc[r]),
            .err_dec_o (err_dec[r])
        );

        assign nz[r] = |cnt[r];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0]    addr;
        logic [WORD_SIZE-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = regs_q[addr];
            if ((ZERO_REG != 0) && (addr == '0)) data = '0;
            else if (wr_en && (wr_addr == addr)) data = wr_data;
        end

        assign rd_data[k*WORD_SIZE +: WORD_SIZE] = data;
        // A lone writeback that empties the counter clears busy this cycle;
        // a same-cycle issue only shows up once the counter has registered it.
        assign rd_busy[k] = nz[addr] && !(dec[addr] && !nz_next[addr]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_err_q  <= 1'b0;
            wb_err_q   <= 1'b0;
            pend_any_q <= 1'b0;
        end else begin
            iss_err_q  <= |err_inc;
            wb_err_q   <= |err_dec;
            pend_any_q <= |nz_next;
        end
    end

    assign iss_err  = iss_err_q;
    assign wb_err   = wb_err_q;
    assign pend_any = pend_any_q;

endmodule
